// File: rtl/sram_controller.sv
// 32-bit load/store port onto a 16-bit asynchronous SRAM: each word moves as a low
// half-word phase followed by a high half-word phase, SRAM_WAIT cycles each.
module sram_controller #(
  parameter int unsigned SRAM_WAIT = 5,
  parameter int unsigned BASE_ADDR = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  inout  wire  [15:0] SRAM_DQ,
  output logic [17:0] SRAM_ADDR,
  output logic        SRAM_WE_N
);

  typedef enum logic [1:0] {StIdle, StLo, StHi, StDone} state_e;

  localparam logic [3:0] LastCnt = 4'(SRAM_WAIT - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        is_write_q, is_write_d;
  logic        req;
  logic        last;
  logic        drive;
  logic [15:0] dq_out;
  logic [31:0] offset;
  logic        unused_offset_bits;

  assign req    = wr_en | rd_en;
  assign last   = (cnt_q == LastCnt);
  assign offset = address - 32'(BASE_ADDR);
  assign unused_offset_bits = ^{offset[31:19], offset[1:0]};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + 4'd1;
    is_write_d = is_write_q;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (req) begin
          state_d    = StLo;
          is_write_d = wr_en;  // write wins when both requests are raised
        end
      end
      StLo: begin
        if (last) begin
          state_d = StHi;
          cnt_d   = '0;
        end
      end
      StHi: begin
        if (last) begin
          state_d = StDone;
          cnt_d   = '0;
        end
      end
      StDone: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    ready     = (state_q == StDone) || ((state_q == StIdle) && !req);
    SRAM_ADDR = '0;
    if (state_q == StLo) SRAM_ADDR = {offset[18:2], 1'b0};
    if (state_q == StHi) SRAM_ADDR = {offset[18:2], 1'b1};
    drive     = is_write_q && ((state_q == StLo) || (state_q == StHi));
    dq_out    = (state_q == StHi) ? write_data[31:16] : write_data[15:0];
    // WE_N released in the final phase cycle so data/address hold past the write edge
    SRAM_WE_N = !(drive && !last);
  end

  assign SRAM_DQ = drive ? dq_out : 16'hzzzz;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      is_write_q <= 1'b0;
      read_data  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_write_q <= is_write_d;
      if (!is_write_q && last && (state_q == StLo)) read_data[15:0]  <= SRAM_DQ;
      if (!is_write_q && last && (state_q == StHi)) read_data[31:16] <= SRAM_DQ;
    end
  end

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: transaction-level model checked every cycle, an SRAM
// array on the bus, and directed transactions with literal expectations.
module tb_sram_controller;

  localparam int W    = 5;
  localparam int BASE = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] write_data = '0;
  logic [31:0] read_data;
  logic        ready;
  wire  [15:0] sram_dq;
  logic [17:0] sram_addr;
  logic        sram_we_n;

  int total = 0;
  int bad   = 0;

  logic [15:0] mem [0:255];
  logic [31:0] wmem [0:127];
  int          we_low_cnt = 0;

  int          m_k = 0, m_k_nxt = 0;
  logic        m_write = 1'b0, m_wr_nxt = 1'b0;
  logic [31:0] m_rd = '0, m_rd_nxt = '0;
  logic        sram_oe;

  sram_controller #(
    .SRAM_WAIT(W),
    .BASE_ADDR(BASE)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .rd_en     (rd_en),
    .address   (address),
    .write_data(write_data),
    .read_data (read_data),
    .ready     (ready),
    .SRAM_DQ   (sram_dq),
    .SRAM_ADDR (sram_addr),
    .SRAM_WE_N (sram_we_n)
  );

  always #5 clk = ~clk;

  // Bench SRAM drives the bus whenever the controller should not be writing it
  assign sram_oe = !(rst && m_write && m_k >= 1 && m_k <= 2 * W);
  assign sram_dq = sram_oe ? mem[sram_addr[7:0]] : 16'hzzzz;

  always @(posedge clk) begin
    if (!sram_we_n) begin
      mem[sram_addr[7:0]] <= sram_dq;
      we_low_cnt <= we_low_cnt + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic        req;
    logic [31:0] w;
    logic        exp_ready, exp_we, in_phase, hi;
    logic [17:0] exp_addr;
    logic [15:0] exp_dq;
    int          j;
    req = wr_en | rd_en;
    w   = (address - 32'(BASE)) >> 2;
    if (!rst) begin
      chk("rst_ready", {31'b0, ready}, {31'b0, !req});
      chk("rst_addr", {14'b0, sram_addr}, 32'd0);
      chk("rst_we_n", {31'b0, sram_we_n}, 32'd1);
      chk("rst_dq", {16'b0, sram_dq}, {16'b0, mem[0]});
      chk("rst_rdata", read_data, 32'd0);
      m_k_nxt  = 0;
      m_wr_nxt = m_write;
      m_rd_nxt = '0;
    end else begin
      m_k_nxt   = m_k;
      m_wr_nxt  = m_write;
      m_rd_nxt  = m_rd;
      exp_ready = 1'b0;
      exp_we    = 1'b1;
      exp_addr  = '0;
      in_phase  = (m_k >= 1) && (m_k <= 2 * W);
      hi        = (m_k > W);
      j         = hi ? m_k - W - 1 : m_k - 1;
      if (m_k == 0) begin
        exp_ready = !req;
        if (req) begin
          m_k_nxt  = 1;
          m_wr_nxt = wr_en;
        end
      end else if (in_phase) begin
        exp_addr = {w[16:0], hi};
        if (m_write) exp_we = (j == W - 1);
        if (!m_write && j == W - 1) begin
          if (hi) m_rd_nxt[31:16] = wmem[w[6:0]][31:16];
          else    m_rd_nxt[15:0]  = wmem[w[6:0]][15:0];
        end
        m_k_nxt = m_k + 1;
      end else begin
        exp_ready = 1'b1;
        if (m_write) wmem[w[6:0]] = write_data;
        m_k_nxt = 0;
      end
      if (in_phase && m_write) exp_dq = hi ? write_data[31:16] : write_data[15:0];
      else                     exp_dq = mem[exp_addr[7:0]];
      chk("ready", {31'b0, ready}, {31'b0, exp_ready});
      chk("sram_addr", {14'b0, sram_addr}, {14'b0, exp_addr});
      chk("we_n", {31'b0, sram_we_n}, {31'b0, exp_we});
      chk("dq", {16'b0, sram_dq}, {16'b0, exp_dq});
      chk("rdata", read_data, m_rd);
    end
  end

  always @(posedge clk) begin
    m_k     <= m_k_nxt;
    m_write <= m_wr_nxt;
    m_rd    <= m_rd_nxt;
  end

  task automatic wait_ready(output int lat);
    lat = 0;
    @(negedge clk);
    while (!ready && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic txn(input logic wr, input logic rd, input logic [31:0] a,
                     input logic [31:0] d, output int lat);
    @(posedge clk);
    #1;
    wr_en = wr;
    rd_en = rd;
    address = a;
    write_data = d;
    wait_ready(lat);
  endtask

  task automatic idle(input int n);
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    repeat (n - 1) @(posedge clk);
  endtask

  initial begin
    int lat;
    int we0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0;
    for (int i = 0; i < 128; i++) wmem[i] = 32'h0;
    mem[0] = 16'h5A5A;

    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("init_ready", {31'b0, ready}, 32'd1);
    chk("init_we_n", {31'b0, sram_we_n}, 32'd1);
    chk("init_dq_released", {16'b0, sram_dq}, 32'h5A5A);
    chk("init_rdata", read_data, 32'd0);

    we0 = we_low_cnt;
    txn(1'b1, 1'b0, 32'd1028, 32'hDEADBEEF, lat);
    chk("wr_lat", lat, 32'd11);
    chk("wr_we_low_cycles", we_low_cnt - we0, 32'd8);
    chk("wr_mem2", {16'b0, mem[2]}, 32'hBEEF);
    chk("wr_mem3", {16'b0, mem[3]}, 32'hDEAD);
    idle(2);

    txn(1'b0, 1'b1, 32'd1028, 32'h0, lat);
    chk("rd_lat", lat, 32'd11);
    chk("rd_data", read_data, 32'hDEADBEEF);
    idle(1);

    txn(1'b1, 1'b1, 32'd1032, 32'h12345678, lat);
    chk("both_lat", lat, 32'd11);
    chk("both_rdata_kept", read_data, 32'hDEADBEEF);
    chk("both_mem4", {16'b0, mem[4]}, 32'h5678);
    chk("both_mem5", {16'b0, mem[5]}, 32'h1234);
    idle(1);

    txn(1'b0, 1'b1, 32'd1032, 32'h0, lat);
    chk("b2b_rd_lat", lat, 32'd11);
    chk("b2b_rd_data", read_data, 32'h12345678);
    txn(1'b1, 1'b0, 32'd1036, 32'hA5A50F0F, lat);
    chk("b2b_wr_lat", lat, 32'd11);
    chk("b2b_mem6", {16'b0, mem[6]}, 32'h0F0F);
    chk("b2b_mem7", {16'b0, mem[7]}, 32'hA5A5);
    idle(1);

    // Address below the base wraps to the top of the SRAM word space
    txn(1'b1, 1'b0, 32'd1020, 32'h0BADF00D, lat);
    chk("wrap_lat", lat, 32'd11);
    chk("wrap_mem_fe", {16'b0, mem[8'hFE]}, 32'hF00D);
    chk("wrap_mem_ff", {16'b0, mem[8'hFF]}, 32'h0BAD);
    idle(1);
    txn(1'b0, 1'b1, 32'd1020, 32'h0, lat);
    chk("wrap_rd_data", read_data, 32'h0BADF00D);
    idle(1);

    @(posedge clk);
    #1;
    wr_en = 1'b1;
    address = 32'd1040;
    write_data = 32'hCAFEF00D;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("abort_we_n", {31'b0, sram_we_n}, 32'd1);
    chk("abort_addr", {14'b0, sram_addr}, 32'd0);
    chk("abort_dq_released", {16'b0, sram_dq}, 32'h5A5A);
    chk("abort_ready", {31'b0, ready}, 32'd0);
    chk("abort_rdata", read_data, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    wait_ready(lat);
    chk("restart_lat", lat, 32'd11);
    chk("restart_mem8", {16'b0, mem[8]}, 32'hF00D);
    chk("restart_mem9", {16'b0, mem[9]}, 32'hCAFE);
    idle(1);

    txn(1'b0, 1'b1, 32'd1040, 32'h0, lat);
    chk("restart_rd_data", read_data, 32'hCAFEF00D);
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sram_controller.md
SRAM_CONTROLLER -- requirements
Module: sram_controller

Interface
REQ-001 Parameter SRAM_WAIT, default 5, clock cycles per 16-bit SRAM phase (legal range 1..15).
REQ-002 Parameter BASE_ADDR, default 1024, data-memory base byte address subtracted before mapping.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 wr_en  input  1  store request from memory stage.
REQ-006 rd_en  input  1  load request from memory stage.
REQ-007 address  input  32  byte address (memory-stage ALU result).
REQ-008 write_data  input  32  store data (memory-stage val_Rm).
REQ-009 read_data  output  32  load result, registered.
REQ-010 ready  output  1  transaction complete or idle; pipeline freezes while low.
REQ-011 SRAM_DQ  inout  16  SRAM data bus.
REQ-012 SRAM_ADDR  output  18  SRAM half-word address.
REQ-013 SRAM_WE_N  output  1  SRAM write enable, active-low.

Function
REQ-014 FSM states IDLE, LO, HI, DONE; one-hot or binary encoding is free.
REQ-015 IDLE: wr_en or rd_en high -> LO, latching op type (write if wr_en, else read); otherwise stay IDLE.
REQ-016 LO and HI each last exactly SRAM_WAIT cycles via a phase counter cleared on every state entry; LO -> HI -> DONE.
REQ-017 DONE lasts one cycle, then IDLE unconditionally.
REQ-018 wr_en and rd_en both high: treated as write; read_data unchanged.
REQ-019 ready = 1 in DONE, 1 in IDLE when no request, 0 otherwise (combinational from state and request).
REQ-020 Latency: request seen in IDLE at cycle 0 -> ready high in cycle 2*SRAM_WAIT+1.
REQ-021 Word index w = (address - BASE_ADDR) >> 2, 32-bit modular subtraction; SRAM_ADDR = {w[16:0], 1'b0} in LO, {w[16:0], 1'b1} in HI.
REQ-022 SRAM_ADDR = 0 in IDLE and DONE.
REQ-023 Write: SRAM_DQ driven with write_data[15:0] in LO, write_data[31:16] in HI; SRAM_WE_N low in all LO/HI cycles except the last cycle of each phase.
REQ-024 Read or idle: SRAM_DQ high-Z and SRAM_WE_N high.
REQ-025 Read: SRAM_DQ captured into read_data[15:0] on last LO cycle, read_data[31:16] on last HI cycle; read_data holds until next read.
REQ-026 address, write_data, and request held stable by upstream until ready; the block samples them each cycle, no internal copy beyond op type.
REQ-027 A request present in the DONE cycle is not restarted; only IDLE starts a transaction.

Reset
REQ-028 rst low: state IDLE, counter 0, read_data 0, SRAM_ADDR 0, SRAM_WE_N 1, SRAM_DQ high-Z, ready 1 when no request, all immediate (asynchronous).
REQ-029 rst asserted mid-transaction aborts it with no further SRAM writes; after release a held request restarts from LO.

Verification
REQ-030 Reset release, no request -> ready 1, SRAM_WE_N 1, SRAM_DQ Z, read_data 0.
REQ-031 SRAM_WAIT=5, wr_en, address 1028, write_data 0xDEADBEEF -> SRAM_ADDR 2 with DQ 0xBEEF for 5 cycles, SRAM_ADDR 3 with DQ 0xDEAD for 5 cycles, WE_N low 4 of each 5, ready high at cycle 11.
REQ-032 rd_en, address 1028 after REQ-031 (SRAM model) -> ready at cycle 11, read_data 0xDEADBEEF.
REQ-033 wr_en and rd_en together, address 1032, data 0x12345678 -> write performed at SRAM_ADDR 4/5, read_data unchanged.
REQ-034 rst low at cycle 3 of a write -> WE_N high and DQ Z immediately, state IDLE; held request after release completes in 11 cycles.
REQ-035 Back-to-back: read then write with ready-driven handoff -> second transaction starts the cycle after DONE, no overlap, each 11 cycles.
